// File: rtl/rr_arb_grant_collector_pkg.sv
// Shared helpers for the round-robin arbiter family: index width and one-hot to index conversion.
package rr_arb_grant_collector_pkg;

  localparam int unsigned MAX_N   = 32;
  localparam int unsigned MAX_IDW = 5;

  // Index width for n sources; a single source still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Binary index of a one-hot vector; zero-extend narrower vectors to MAX_N before calling.
  function automatic logic [MAX_IDW-1:0] onehot2idx(input logic [MAX_N-1:0] oh);
    logic [MAX_IDW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx |= MAX_IDW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_grant_collector_out_fifo.sv
// Synchronous output FIFO for the grant collector; storage is cleared on reset so the head reads zero.
module rr_arb_out_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign count   = cnt_q;

endmodule

// File: rtl/rr_arb_grant_collector.sv
// Grant collector: presents source requests to a registered-grant arbiter, pops granted sources
// into an output FIFO, and throttles the arbiter so a returning grant always finds a free entry.
module rr_arb_grant_collector
  import rr_arb_grant_collector_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0]               src_valid,
  input  logic [N*DW-1:0]            src_data,
  output logic [N-1:0]               src_ready,
  output logic [N-1:0]               arb_req,
  output logic                       arb_en,
  input  logic [N-1:0]               arb_gnt,
  input  logic                       arb_gnt_vld,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic [idx_width(N)-1:0]    out_id,
  output logic                       gnt_drop
);

  localparam int unsigned IDW = idx_width(N);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned LW  = CW + 1;

  logic               run_q;
  logic               inflight_q;
  logic               live_c;
  logic               wr_c;
  logic               deq_c;
  logic [N-1:0]       pop_c;
  logic [IDW-1:0]     wr_id_c;
  logic [DW-1:0]      wr_dat_c;
  logic [LW-1:0]      level_c;
  logic [CW-1:0]      count;
  logic [DW+IDW-1:0]  rd_data;

  // run_q keeps requests and pops quiet until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= arb_en & (|arb_req);
    end
  end

  // Pop only on a live, one-hot grant whose source is still valid; anything else is dropped.
  always_comb begin
    live_c = run_q & arb_gnt_vld & (|arb_gnt);
    pop_c  = '0;
    if (live_c && $onehot(arb_gnt)) pop_c = arb_gnt & src_valid;
    wr_c     = |pop_c;
    wr_id_c  = IDW'(onehot2idx(MAX_N'(pop_c)));
    wr_dat_c = src_data[wr_id_c*DW +: DW];
  end

  assign src_ready = pop_c;
  assign gnt_drop  = live_c & ~wr_c;
  assign arb_req   = run_q ? (src_valid & ~pop_c) : '0;

  // Occupancy after this cycle assuming the in-flight grant writes; a new request is
  // enabled only if its grant next cycle is guaranteed a free slot.
  assign deq_c   = out_valid & out_ready;
  assign level_c = LW'(count) - LW'(deq_c) + LW'(inflight_q);
  assign arb_en  = run_q & (level_c < LW'(DEPTH));

  rr_arb_out_fifo #(
    .W     (DW + IDW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_c),
    .wr_data ({wr_id_c, wr_dat_c}),
    .rd_en   (deq_c),
    .rd_data (rd_data),
    .count   (count)
  );

  assign out_valid = (count != '0);
  assign out_id    = rd_data[DW +: IDW];
  assign out_data  = rd_data[DW-1:0];

endmodule
